// File: rtl/powerup_effect_manager_if.sv
// ---------------------------------------------------------------------------
// powerup_effect_manager_if
// Bundles the power-up collect request, the player-hit pulse and every
// effect/lives/tint output of powerup_effect_manager.
//   master : producer side (collision/selector logic, testbench)
//            drives collect, speedup, extralife, shootfaster, doublescore,
//            life_lost; observes all status outputs.
//   slave  : powerup_effect_manager itself.
// ---------------------------------------------------------------------------
interface powerup_effect_manager_if;
  logic        collect;
  logic        speedup;
  logic        extralife;
  logic        shootfaster;
  logic        doublescore;
  logic        life_lost;
  logic        consumed;
  logic        speed_active;
  logic        shoot_active;
  logic        double_active;
  logic        warn;
  logic [15:0] remaining;
  logic [2:0]  lives;
  logic        game_over;
  logic [3:0]  tint_red;
  logic [3:0]  tint_green;
  logic [3:0]  tint_blue;

  modport master (
    output collect, speedup, extralife, shootfaster, doublescore, life_lost,
    input  consumed, speed_active, shoot_active, double_active, warn,
    input  remaining, lives, game_over, tint_red, tint_green, tint_blue
  );

  modport slave (
    input  collect, speedup, extralife, shootfaster, doublescore, life_lost,
    output consumed, speed_active, shoot_active, double_active, warn,
    output remaining, lives, game_over, tint_red, tint_green, tint_blue
  );
endinterface

// File: rtl/powerup_effect_manager.sv
// ---------------------------------------------------------------------------
// powerup_effect_manager
// Applies a collected power-up: timed effects (speed, shoot, double score)
// run for DURATION frames, extralife adds a life. Tracks lives, drives a
// one-frame consume pulse back to the spawn logic and a blinking ship tint.
// Ports:
//   frame_clk : frame clock, all state updates on its rising edge
//   Reset     : asynchronous active-high reset
//   bus       : powerup_effect_manager_if.slave (collect/type flags,
//               life_lost in; consumed, *_active, warn, remaining, lives,
//               game_over, tint_* out)
// ---------------------------------------------------------------------------
module powerup_effect_manager #(
  parameter int unsigned DURATION    = 600,
  parameter int unsigned WARN_FRAMES = 120,
  parameter int unsigned INIT_LIVES  = 3,
  parameter int unsigned MAX_LIVES   = 5
) (
  input  logic                         frame_clk,
  input  logic                         Reset,
  powerup_effect_manager_if.slave      bus
);

  localparam logic [15:0] DUR16  = 16'(DURATION);
  localparam logic [15:0] WARN16 = 16'(WARN_FRAMES);
  localparam logic [2:0]  INIT3  = 3'(INIT_LIVES);
  localparam logic [2:0]  MAX3   = 3'(MAX_LIVES);

  typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;
  typedef enum logic [1:0] {E_SPEED = 2'd0, E_SHOOT = 2'd1, E_DOUBLE = 2'd2} effect_t;

  // True when exactly one bit of the type vector is set.
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  state_t      r_state;
  effect_t     r_effect;
  logic [15:0] r_remaining;
  logic [2:0]  r_lives;
  logic        r_consumed;
  logic        r_speed_active;
  logic        r_shoot_active;
  logic        r_double_active;

  logic [3:0]  w_types;
  logic        w_game_over;
  logic        w_valid;
  logic        w_timed;
  logic        w_life_inc;
  effect_t     w_new_effect;
  logic        w_warn;
  logic [11:0] w_tint_base;
  logic [11:0] w_tint;

  assign w_types     = {bus.speedup, bus.extralife, bus.shootfaster, bus.doublescore};
  assign w_game_over = (r_lives == 3'd0);
  // A level collect is accepted once: the cycle it shows consumed is blocked.
  assign w_valid     = bus.collect && is_onehot4(w_types) && !w_game_over && !r_consumed;
  assign w_timed     = w_valid && !bus.extralife;
  assign w_life_inc  = w_valid && bus.extralife;

  // Decode the requested timed effect from the one-hot type flags.
  always_comb begin
    w_new_effect = E_SPEED;
    if (bus.shootfaster) begin
      w_new_effect = E_SHOOT;
    end else if (bus.doublescore) begin
      w_new_effect = E_DOUBLE;
    end else begin
      w_new_effect = E_SPEED;
    end
  end

  // Effect FSM, timer, consume pulse and registered effect flags.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state         <= S_IDLE;
      r_effect        <= E_SPEED;
      r_remaining     <= 16'd0;
      r_consumed      <= 1'b0;
      r_speed_active  <= 1'b0;
      r_shoot_active  <= 1'b0;
      r_double_active <= 1'b0;
    end else begin
      r_consumed <= w_valid;
      if (bus.life_lost) begin
        // A hit cancels any running effect, even one collected this frame.
        r_state         <= S_IDLE;
        r_remaining     <= 16'd0;
        r_speed_active  <= 1'b0;
        r_shoot_active  <= 1'b0;
        r_double_active <= 1'b0;
      end else if (w_timed) begin
        r_state         <= S_ACTIVE;
        r_effect        <= w_new_effect;
        r_remaining     <= DUR16;
        r_speed_active  <= (w_new_effect == E_SPEED);
        r_shoot_active  <= (w_new_effect == E_SHOOT);
        r_double_active <= (w_new_effect == E_DOUBLE);
      end else begin
        case (r_state)
          S_ACTIVE: begin
            if (r_remaining <= 16'd1) begin
              r_state         <= S_IDLE;
              r_remaining     <= 16'd0;
              r_speed_active  <= 1'b0;
              r_shoot_active  <= 1'b0;
              r_double_active <= 1'b0;
            end else begin
              r_remaining <= r_remaining - 16'd1;
            end
          end
          S_IDLE: begin
            r_remaining <= 16'd0;
          end
          default: begin
            r_state         <= S_IDLE;
            r_remaining     <= 16'd0;
            r_speed_active  <= 1'b0;
            r_shoot_active  <= 1'b0;
            r_double_active <= 1'b0;
          end
        endcase
      end
    end
  end

  // Life counter: saturating increment/decrement, simultaneous events cancel.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_lives <= INIT3;
    end else if (w_life_inc && !bus.life_lost) begin
      r_lives <= (r_lives < MAX3) ? (r_lives + 3'd1) : MAX3;
    end else if (!w_life_inc && bus.life_lost) begin
      r_lives <= (r_lives != 3'd0) ? (r_lives - 3'd1) : 3'd0;
    end else begin
      r_lives <= r_lives;
    end
  end

  assign w_warn = (r_state == S_ACTIVE) && (r_remaining <= WARN16);

  // Ship tint per active effect, blanked on alternate 8-frame halves in warning.
  always_comb begin
    w_tint_base = 12'h000;
    if (r_state == S_ACTIVE) begin
      case (r_effect)
        E_SPEED:  w_tint_base = 12'h00F;
        E_SHOOT:  w_tint_base = 12'h0F0;
        E_DOUBLE: w_tint_base = 12'hFF0;
        default:  w_tint_base = 12'h000;
      endcase
    end else begin
      w_tint_base = 12'h000;
    end
    if (w_warn && r_remaining[3]) begin
      w_tint = 12'h000;
    end else begin
      w_tint = w_tint_base;
    end
  end

  assign bus.consumed      = r_consumed;
  assign bus.speed_active  = r_speed_active;
  assign bus.shoot_active  = r_shoot_active;
  assign bus.double_active = r_double_active;
  assign bus.warn          = w_warn;
  assign bus.remaining     = r_remaining;
  assign bus.lives         = r_lives;
  assign bus.game_over     = w_game_over;
  assign bus.tint_red      = w_tint[11:8];
  assign bus.tint_green    = w_tint[7:4];
  assign bus.tint_blue     = w_tint[3:0];

endmodule
